bus_ram: RTL and testbench
==========================

// Module: bus_ram
// PURPOSE
//  Word-organised RAM on the far side of the CPU's shared bus: decodes bus_addr and ram_cs/ram_we/ram_oe.
//  On reads it drives the tri-state bus_data; on writes it captures bus_data.
//  A built-in loader FSM accepts a program image over a valid/ready stream while cpu_hold keeps the CPU in reset.
//  Once loading is complete, it hands the bus over to the CPU.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 64-bit words; power of two, >=2
//  AW           $clog2(DEPTH_WORDS)  word-index width (localparam, derived)
//  SKIP_LOAD    0     1: leave reset directly in RUN (image preloaded by simulation $readmemh)
// PORTS
//  clk          in     1   rising-edge clock
//  reset        in     1   asynchronous, active-high
//  bus_addr     in     64  byte address from CPU
//  bus_data     inout  64  shared data bus; driven only during a valid read, else 'Z
//  ram_cs       in     1   chip select
//  ram_we       in     1   write enable
//  ram_oe       in     1   output (read) enable
//  load_valid   in     1   loader beat valid
//  load_data    in     64  loader word (instruction in [63:32])
//  load_last    in     1   qualifies final beat
//  load_ready   out    1   loader may present beat
//  load_done    out    1   image loaded, RUN state
//  cpu_hold     out    1   hold CPU in reset while 1
//  err          out    2   sticky first error: 00 none, 01 out-of-range, 10 misaligned, 11 we&oe conflict
// BEHAVIOUR
//  Reset values: state=LOAD (RUN if SKIP_LOAD), load_ptr=0, load_ready=1 (0 if SKIP_LOAD), load_done=0 (1),
//   cpu_hold=1 (0), err=00; bus_data released to 'Z immediately (async). Memory array is NOT reset.
//  Address decode: idx=bus_addr[AW+2:3]; in_range = (bus_addr[63:AW+3]==0); aligned = (bus_addr[2:0]==0).
//  FSM LOAD:
//   - beat accepted on posedge with load_valid&&load_ready: mem[load_ptr]<=load_data; load_ptr<=load_ptr+1
//   - accepted beat with load_last=1, or accepted beat at load_ptr==DEPTH_WORDS-1 -> RUN next cycle
//   - load_ready=1 throughout LOAD; ram_cs/we/oe ignored, bus_data='Z, err not updated
//  FSM RUN (terminal until reset): load_ready=0, load_done=1, cpu_hold=0; load_valid ignored.
//  Read in RUN (ram_cs&&ram_oe&&!ram_we): combinational, zero latency;
//   bus_data = in_range ? mem[idx] : 64'h0, valid in the same cycle the CPU samples it.
//  Write in RUN (ram_cs&&ram_we&&!ram_oe): on posedge, mem[idx]<=bus_data only if in_range;
//   a read of the same idx in the following cycle returns the new data.
//  Misaligned access: the low 3 bits are dropped (floor to word) and the access still completes.
//  Conflict ram_we&&ram_oe&&ram_cs: no write, bus_data='Z.
//  Error capture: err latches on posedge only while err==00; the highest-numbered of the cycle's errors wins;
//   only reset clears it.
//  Reset mid-load: returns to LOAD with load_ptr=0; words already written remain until overwritten.
//  Reset during RUN: CPU re-held; image must be reloaded unless SKIP_LOAD.
// TESTING
//  1 reset, stream 3 beats A,B,C (last on C) -> mem[0..2]=A,B,C; load_done=1, cpu_hold=0 one cycle after C
//  2 RUN: cs,we, addr=0x10, bus_data=0xDEAD_BEEF; next cycle cs,oe -> bus_data=0xDEAD_BEEF same cycle, err=00
//  3 RUN: read addr=(DEPTH_WORDS*8) -> bus_data=0, err=01; later write same addr -> no mem change, err stays 01
//  4 RUN: cs,we,oe together at addr 0 -> mem[0] unchanged, bus_data='Z, err=11 (fresh reset first)
//  5 stream DEPTH_WORDS beats with load_last=0 -> RUN after beat DEPTH_WORDS-1; extra load_valid ignored
//  6 assert reset after 2 of 4 beats -> load_ptr=0, cpu_hold=1; re-stream 4 beats -> mem[0..3] = new image

Source files
------------

// File: rtl/bus_ram_if.sv
// bus_ram_if: CPU-side bus and program-loader stream of bus_ram.
//   bus_addr/ram_cs/ram_we/ram_oe : CPU address and strobes
//   load_valid/load_data/load_last/load_ready : program-image stream
//   load_done/cpu_hold/err : status back to the system
// The shared tri-state bus_data stays a plain inout port on bus_ram,
// so the resolved net stays a single wire owned by the bench or top level.
interface bus_ram_if;
  logic [63:0] bus_addr;
  logic        ram_cs;
  logic        ram_we;
  logic        ram_oe;
  logic        load_valid;
  logic [63:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic        cpu_hold;
  logic [1:0]  err;

  modport master (
    output bus_addr, ram_cs, ram_we, ram_oe,
    output load_valid, load_data, load_last,
    input  load_ready, load_done, cpu_hold, err
  );

  modport slave (
    input  bus_addr, ram_cs, ram_we, ram_oe,
    input  load_valid, load_data, load_last,
    output load_ready, load_done, cpu_hold, err
  );
endinterface

// File: rtl/bus_ram.sv
// bus_ram: word-organised 64-bit RAM on the CPU's shared bus, with a
// built-in loader that streams a program image in while the CPU is held.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : bus_ram_if.slave (address/strobes, loader stream, status)
//   bus_data   : shared tri-state data bus, driven only during a valid read
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_LOAD | accepting image beats, CPU held in reset, bus ignored
// ST_RUN  | image loaded, CPU released, RAM serves bus reads/writes
module bus_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter bit SKIP_LOAD   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  bus_ram_if.slave    bus,
  inout  wire  [63:0] bus_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t          state;
  logic [AW-1:0]   load_ptr;
  logic            load_ready_q;
  logic            load_done_q;
  logic            cpu_hold_q;
  logic [1:0]      err_q;
  logic [1:0]      err_next;

  logic [63:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   idx;
  logic            in_range;
  logic            aligned;
  logic            run;
  logic            access;
  logic            rd_en;
  logic            wr_en;
  logic            conflict;
  logic            beat;
  logic [63:0]     rd_data;

  // Byte address to word index; low three bits are dropped, so a
  // misaligned access completes on the enclosing word.
  assign idx      = bus.bus_addr[AW+2:3];
  assign in_range = (bus.bus_addr[63:AW+3] == '0);
  assign aligned  = (bus.bus_addr[2:0] == 3'b000);

  // The bus is only decoded in RUN; during LOAD the strobes are ignored.
  assign run      = (state == ST_RUN);
  assign access   = run && bus.ram_cs && (bus.ram_we || bus.ram_oe);
  assign rd_en    = run && bus.ram_cs && bus.ram_oe && !bus.ram_we;
  assign wr_en    = run && bus.ram_cs && bus.ram_we && !bus.ram_oe;
  assign conflict = run && bus.ram_cs && bus.ram_we && bus.ram_oe;

  assign beat     = (state == ST_LOAD) && bus.load_valid && load_ready_q;

  // Zero-latency read; out-of-range reads return zero rather than aliasing.
  assign rd_data  = in_range ? mem[idx] : 64'h0;

  // rd_en depends on the async-reset state, so reset releases the bus
  // immediately without waiting for a clock.
  assign bus_data = rd_en ? rd_data : 'z;

  assign bus.load_ready = load_ready_q;
  assign bus.load_done  = load_done_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.err        = err_q;

  // Later assignments override earlier ones: highest-numbered error wins.
  always_comb begin
    err_next = 2'b00;
    if (access && !in_range) err_next = 2'b01;
    if (access && !aligned)  err_next = 2'b10;
    if (conflict)            err_next = 2'b11;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SKIP_LOAD ? ST_RUN : ST_LOAD;
      load_ptr     <= '0;
      load_ready_q <= !SKIP_LOAD;
      load_done_q  <= SKIP_LOAD;
      cpu_hold_q   <= !SKIP_LOAD;
      err_q        <= 2'b00;
    end else begin
      case (state)
        ST_LOAD: begin
          if (beat) begin
            load_ptr <= load_ptr + 1'b1;
            // An image filling the whole array ends the load even
            // without load_last.
            if (bus.load_last || (load_ptr == LAST_IDX)) begin
              state        <= ST_RUN;
              load_ready_q <= 1'b0;
              load_done_q  <= 1'b1;
              cpu_hold_q   <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          // First error is sticky until reset.
          if (err_q == 2'b00) err_q <= err_next;
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

  // Storage is deliberately not reset: a reset mid-load keeps the words
  // already written, and SKIP_LOAD relies on a preloaded image.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem[load_ptr] <= bus.load_data;
    end else if (wr_en && in_range) begin
      mem[idx] <= bus_data;
    end
  end

endmodule

// File: tb/tb_bus_ram.sv
module tb_bus_ram;

  localparam int DEPTH = 16;

  localparam logic [63:0] IMG_A = 64'h1111_2222_0000_0001;
  localparam logic [63:0] IMG_B = 64'h3333_4444_0000_0002;
  localparam logic [63:0] IMG_C = 64'h5555_6666_0000_0003;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_ram_if bif();

  wire  [63:0] bus_data;
  logic        drv_en;
  logic [63:0] drv_val;
  assign bus_data = drv_en ? drv_val : 'z;

  bus_ram #(
    .DEPTH_WORDS(DEPTH),
    .SKIP_LOAD  (1'b0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bif.slave),
    .bus_data(bus_data)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bif.bus_addr   = '0;
    bif.ram_cs     = 1'b0;
    bif.ram_we     = 1'b0;
    bif.ram_oe     = 1'b0;
    bif.load_valid = 1'b0;
    bif.load_data  = '0;
    bif.load_last  = 1'b0;
    drv_en         = 1'b0;
    drv_val        = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns at the negedge after the accepting posedge.
  task automatic send_beat(input logic [63:0] d, input logic last);
    @(negedge clk);
    bif.load_valid = 1'b1;
    bif.load_data  = d;
    bif.load_last  = last;
    @(negedge clk);
    bif.load_valid = 1'b0;
    bif.load_last  = 1'b0;
  endtask

  task automatic load_abc();
    send_beat(IMG_A, 1'b0);
    send_beat(IMG_B, 1'b0);
    send_beat(IMG_C, 1'b1);
  endtask

  task automatic rd(input logic [63:0] a, output logic [63:0] d);
    @(negedge clk);
    bif.bus_addr = a;
    bif.ram_cs   = 1'b1;
    bif.ram_oe   = 1'b1;
    bif.ram_we   = 1'b0;
    drv_en       = 1'b0;
    #1 d = bus_data;
    @(negedge clk);
    bif.ram_cs = 1'b0;
    bif.ram_oe = 1'b0;
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    bif.bus_addr = a;
    bif.ram_cs   = 1'b1;
    bif.ram_we   = 1'b1;
    bif.ram_oe   = 1'b0;
    drv_en       = 1'b1;
    drv_val      = d;
    @(negedge clk);
    bif.ram_cs = 1'b0;
    bif.ram_we = 1'b0;
    drv_en     = 1'b0;
  endtask

  logic [63:0] d;

  initial begin
    reset = 1'b1;
    idle();

    // 1: reset state, 3-beat load
    do_reset();
    chk("rst_ready", {63'h0, bif.load_ready}, 64'd1);
    chk("rst_done",  {63'h0, bif.load_done},  64'd0);
    chk("rst_hold",  {63'h0, bif.cpu_hold},   64'd1);
    chk("rst_err",   {62'h0, bif.err},        64'd0);
    send_beat(IMG_A, 1'b0);
    send_beat(IMG_B, 1'b0);
    chk("t1_done_before_c", {63'h0, bif.load_done}, 64'd0);
    send_beat(IMG_C, 1'b1);
    chk("t1_done",  {63'h0, bif.load_done},  64'd1);
    chk("t1_hold",  {63'h0, bif.cpu_hold},   64'd0);
    chk("t1_ready", {63'h0, bif.load_ready}, 64'd0);
    rd(64'h00, d); chk("t1_mem0", d, IMG_A);
    rd(64'h08, d); chk("t1_mem1", d, IMG_B);
    rd(64'h10, d); chk("t1_mem2", d, IMG_C);

    // 2: write then read back next cycle
    wr(64'h10, 64'hDEAD_BEEF);
    rd(64'h10, d); chk("t2_rdback", d, 64'hDEAD_BEEF);
    chk("t2_err", {62'h0, bif.err}, 64'd0);

    // 3: out-of-range read returns 0, write is dropped, err sticky at 01
    rd(64'(DEPTH * 8), d); chk("t3_oor_rd", d, 64'h0);
    chk("t3_err", {62'h0, bif.err}, 64'd1);
    wr(64'(DEPTH * 8), 64'h1234_5678);
    rd(64'h00, d); chk("t3_mem0_kept", d, IMG_A);
    chk("t3_err_sticky", {62'h0, bif.err}, 64'd1);

    // misaligned + out-of-range in one access: misaligned wins
    do_reset();
    load_abc();
    rd(64'(DEPTH * 8 + 1), d); chk("mis_oor_rd", d, 64'h0);
    chk("mis_err", {62'h0, bif.err}, 64'd2);
    wr(64'h19, 64'hCAFE_F00D_0000_0019);
    rd(64'h18, d); chk("mis_rd_floor", d, 64'hCAFE_F00D_0000_0019);
    rd(64'h1F, d); chk("mis_rd_hi",    d, 64'hCAFE_F00D_0000_0019);
    chk("mis_err_sticky", {62'h0, bif.err}, 64'd2);

    // 4: we&oe conflict, bench drives 0 so any DUT drive shows up
    do_reset();
    load_abc();
    @(negedge clk);
    bif.bus_addr = 64'h0;
    bif.ram_cs   = 1'b1;
    bif.ram_we   = 1'b1;
    bif.ram_oe   = 1'b1;
    drv_en       = 1'b1;
    drv_val      = 64'h0;
    #1 chk("t4_bus_released", bus_data, 64'h0);
    @(negedge clk);
    idle();
    chk("t4_err", {62'h0, bif.err}, 64'd3);
    rd(64'h00, d); chk("t4_mem0_kept", d, IMG_A);

    // 5: full-depth load without load_last
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("t5_done_before_last", {63'h0, bif.load_done}, 64'd0);
      send_beat({32'h1000 + 32'(i), 32'hC0DE_0000}, 1'b0);
    end
    chk("t5_done",  {63'h0, bif.load_done},  64'd1);
    chk("t5_ready", {63'h0, bif.load_ready}, 64'd0);
    send_beat(64'hBAD0_BAD0_BAD0_BAD0, 1'b1);
    rd(64'h00, d); chk("t5_mem0", d, {32'h1000, 32'hC0DE_0000});
    rd(64'(8 * (DEPTH - 1)), d); chk("t5_memlast", d, {32'h1000 + 32'(DEPTH - 1), 32'hC0DE_0000});

    // 6: reset mid-load, reload
    do_reset();
    send_beat(64'hAAAA_0000_0000_0000, 1'b0);
    send_beat(64'hAAAA_0001_0000_0000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_hold",  {63'h0, bif.cpu_hold},   64'd1);
    chk("t6_ready", {63'h0, bif.load_ready}, 64'd1);
    chk("t6_done",  {63'h0, bif.load_done},  64'd0);
    // reads are ignored during LOAD even though mem[0] holds data
    @(negedge clk);
    bif.bus_addr = 64'h0;
    bif.ram_cs   = 1'b1;
    bif.ram_oe   = 1'b1;
    drv_en       = 1'b1;
    drv_val      = 64'h0;
    #1 chk("t6_load_bus_released", bus_data, 64'h0);
    @(negedge clk);
    idle();
    chk("t6_load_err", {62'h0, bif.err}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      send_beat({32'hBEEF_0000 + 32'(i), 32'h0}, i == 3);
    end
    chk("t6_done_after", {63'h0, bif.load_done}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      rd(64'(8 * i), d);
      chk($sformatf("t6_mem%0d", i), d, {32'hBEEF_0000 + 32'(i), 32'h0});
    end
    rd(64'h20, d); chk("t6_mem4_retained", d, {32'h1004, 32'hC0DE_0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
